// File: rtl/audio_align_pkg.sv
// audio_align_pkg: shared FSM state encoding and counter limits for the sample aligner
package audio_align_pkg;
  typedef enum logic [1:0] {SYNC = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;
  localparam logic [7:0] OVF_MAX = 8'hFF;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with wrap-bit pointers and synchronous flush
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_rd, do_wr;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = mem[rp[AW-1:0]];
  assign do_rd   = rd_en && !empty;
  // a full FIFO may still accept a write when its head leaves in the same cycle
  assign do_wr   = wr_en && (!full || do_rd);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_wr);
      rp <= rp + (AW+1)'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr && !flush) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/dual_sample_aligner.sv
// dual_sample_aligner: pairs skewed ref/mic sample streams into aligned valid/ready pairs
module dual_sample_aligner
  import audio_align_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int SKEW_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ref_data,
  input  logic              ref_wren,
  input  logic [DATA_W-1:0] mic_data,
  input  logic              mic_wren,
  input  logic              pair_ready,
  output logic              pair_valid,
  output logic [DATA_W-1:0] pair_ref,
  output logic [DATA_W-1:0] pair_mic,
  output logic              locked,
  output logic [7:0]        ovf_cnt
);
  localparam int SW = $clog2(SKEW_MAX);
  state_t state, state_n;
  logic [SW-1:0] skew_cnt;
  logic act, in_sync, in_arm, ref_we, mic_we, timeout, ovf, flush, pop;
  logic ref_full, ref_empty, mic_full, mic_empty;
  logic [DATA_W-1:0] ref_head, mic_head;
  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ref (
    .clk(clk), .rst_n(rst_n), .wr_en(ref_we), .wr_data(ref_data), .rd_en(pop),
    .flush(flush), .rd_data(ref_head), .full(ref_full), .empty(ref_empty));
  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mic (
    .clk(clk), .rst_n(rst_n), .wr_en(mic_we), .wr_data(mic_data), .rd_en(pop),
    .flush(flush), .rd_data(mic_head), .full(mic_full), .empty(mic_empty));
  assign locked = state == RUN;
  assign pop    = !ref_empty && !mic_empty && (!pair_valid || pair_ready);
  // act stays low for the first edge after reset release so strobes there are ignored
  always_comb begin
    in_sync = state == SYNC;
    in_arm  = state == ARM;
    ref_we  = act && ref_wren;
    mic_we  = act && mic_wren && (!in_sync || ref_wren);
    timeout = in_arm && !mic_we && skew_cnt == SW'(SKEW_MAX-1);
    ovf     = !in_sync && !pop && ((ref_we && ref_full) || (mic_we && mic_full));
    flush   = ovf || timeout;
    state_n = flush ? SYNC :
              in_sync ? (ref_we ? (mic_we ? RUN : ARM) : SYNC) :
              (in_arm && mic_we) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act        <= 1'b0;
      state      <= SYNC;
      skew_cnt   <= '0;
      ovf_cnt    <= '0;
      pair_valid <= 1'b0;
      pair_ref   <= '0;
      pair_mic   <= '0;
    end else begin
      act      <= 1'b1;
      state    <= state_n;
      skew_cnt <= in_arm ? skew_cnt + 1'b1 : '0;
      ovf_cnt  <= (ovf && ovf_cnt != OVF_MAX) ? ovf_cnt + 8'd1 : ovf_cnt;
      if (pop) begin
        pair_valid <= 1'b1;
        pair_ref   <= ref_head;
        pair_mic   <= mic_head;
      end else if (pair_ready) pair_valid <= 1'b0;
    end
endmodule

// File: tb/tb_dual_sample_aligner.sv
// tb_dual_sample_aligner: lock table, hand-written corner sequences and a randomized stream vs a queue model
module tb_dual_sample_aligner;
  logic clk = 0, rst_n = 0, ref_wren = 0, mic_wren = 0, pair_ready = 0;
  logic [15:0] ref_data = 0, mic_data = 0, pair_ref, pair_mic;
  logic pair_valid, locked;
  logic [7:0] ovf_cnt;
  int checks = 0, errors = 0;
  typedef struct {int dly; logic [15:0] r; logic [15:0] m; bit lk;} vec_t;
  vec_t vecs[7];
  int t_ref[1000];
  logic [15:0] rv[1000], mv[1000];
  dual_sample_aligner dut (
    .clk(clk), .rst_n(rst_n), .ref_data(ref_data), .ref_wren(ref_wren),
    .mic_data(mic_data), .mic_wren(mic_wren), .pair_ready(pair_ready),
    .pair_valid(pair_valid), .pair_ref(pair_ref), .pair_mic(pair_mic),
    .locked(locked), .ovf_cnt(ovf_cnt));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic do_reset;
    rst_n = 0;
    ref_wren = 0;
    mic_wren = 0;
    tick;
    tick;
    rst_n = 1;
    tick;
  endtask
  // ref strobes at relative cycle 0, mic at v.dly; lock expected when 0 <= dly <= 64
  task automatic run_vec(input vec_t v);
    int lo = v.dly < 0 ? v.dly : 0;
    int hi = v.dly > 0 ? v.dly : 0;
    pair_ready = 1;
    for (int c = lo; c <= hi; c++) begin
      ref_wren = c == 0;
      ref_data = v.r;
      mic_wren = c == v.dly;
      mic_data = v.m;
      tick;
    end
    ref_wren = 0;
    mic_wren = 0;
    chk($sformatf("lock_dly%0d", v.dly), locked, v.lk);
    tick;
    chk($sformatf("valid_dly%0d", v.dly), pair_valid, v.lk);
    if (v.lk) chk($sformatf("pair_dly%0d", v.dly), {pair_ref, pair_mic}, {v.r, v.m});
    tick;
    chk($sformatf("once_dly%0d", v.dly), pair_valid, 0);
  endtask
  initial begin
    logic v, rdy;
    logic [15:0] pr, pm;
    int t, ri, mi, k, t_end;
    vecs[0] = '{0, 16'h8000, 16'h7FFF, 1};
    vecs[1] = '{20, 16'h1111, 16'h2222, 1};
    vecs[2] = '{1, 16'hFFFF, 16'h0001, 1};
    vecs[3] = '{63, 16'h1234, 16'hABCD, 1};
    vecs[4] = '{64, 16'h0F0F, 16'hF0F0, 1};
    vecs[5] = '{65, 16'h3333, 16'h4444, 0};
    vecs[6] = '{-5, 16'h5555, 16'h6666, 0};
    #2;
    chk("rst_valid", pair_valid, 0);
    chk("rst_lock", locked, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_pair", {pair_ref, pair_mic}, 0);
    for (int i = 0; i < 7; i++) begin
      do_reset;
      run_vec(vecs[i]);
    end
    // skew timeout: mic after timeout is discarded, and the stale ref was flushed
    do_reset;
    ref_wren = 1; ref_data = 16'hBEEF; tick; ref_wren = 0;
    repeat (70) tick;
    mic_wren = 1; mic_data = 16'hCAFE; tick; mic_wren = 0;
    chk("t2_lock", locked, 0);
    chk("t2_ovf", ovf_cnt, 0);
    tick;
    chk("t2_valid", pair_valid, 0);
    pair_ready = 1;
    ref_wren = 1; ref_data = 16'h0A0A; tick; ref_wren = 0;
    tick;
    mic_wren = 1; mic_data = 16'h0B0B; tick; mic_wren = 0;
    chk("t2_relock", locked, 1);
    tick;
    chk("t2_fresh_pair", {pair_valid, pair_ref, pair_mic}, {1'b1, 16'h0A0A, 16'h0B0B});
    // back-pressure overflow
    do_reset;
    pair_ready = 0;
    ref_wren = 1; mic_wren = 1; ref_data = 16'hA5A5; mic_data = 16'h5A5A; tick;
    ref_wren = 0; mic_wren = 0; tick;
    for (int i = 0; i < 8; i++) begin
      ref_wren = 1; mic_wren = 1; ref_data = 16'(i); mic_data = ~16'(i); tick;
    end
    ref_wren = 0; mic_wren = 0;
    chk("t3_lock", locked, 1);
    chk("t3_held", {pair_valid, pair_ref, pair_mic}, {1'b1, 16'hA5A5, 16'h5A5A});
    chk("t3_ovf0", ovf_cnt, 0);
    ref_wren = 1; ref_data = 16'h0009; tick; ref_wren = 0;
    chk("t3_ovf1", ovf_cnt, 1);
    chk("t3_unlock", locked, 0);
    chk("t3_survive", {pair_valid, pair_ref, pair_mic}, {1'b1, 16'hA5A5, 16'h5A5A});
    pair_ready = 1; tick;
    chk("t3_drain", pair_valid, 0);
    // async reset mid-RUN with half-full FIFOs
    pair_ready = 0;
    ref_wren = 1; mic_wren = 1; ref_data = 16'hC0DE; mic_data = 16'hDEC0; tick;
    ref_wren = 0; mic_wren = 0; tick;
    for (int i = 0; i < 4; i++) begin
      ref_wren = 1; mic_wren = 1; ref_data = 16'(i); mic_data = 16'(i); tick;
    end
    ref_wren = 0; mic_wren = 0;
    chk("t6_pre_lock", locked, 1);
    chk("t6_pre_valid", pair_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_valid", pair_valid, 0);
    chk("t6_lock", locked, 0);
    chk("t6_ovf", ovf_cnt, 0);
    tick;
    #2 rst_n = 1;
    ref_wren = 1; mic_wren = 1; tick; ref_wren = 0; mic_wren = 0;
    chk("t6_ignore_lock", locked, 0);
    tick;
    chk("t6_ignore_valid", pair_valid, 0);
    run_vec(vecs[1]);
    // steady randomized stream, mic lagging ref by 5 cycles
    do_reset;
    t = 5;
    for (int i = 0; i < 1000; i++) begin
      t_ref[i] = t;
      t += $urandom_range(8, 16);
      rv[i] = 16'($urandom);
      mv[i] = 16'($urandom);
    end
    t_end = t_ref[999] + 5;
    ri = 0; mi = 0; k = 0;
    for (int c = 0; c < t_end + 100 && k < 1000; c++) begin
      ref_wren = ri < 1000 && t_ref[ri] == c;
      if (ref_wren) begin ref_data = rv[ri]; ri++; end
      mic_wren = mi < 1000 && t_ref[mi] + 5 == c;
      if (mic_wren) begin mic_data = mv[mi]; mi++; end
      pair_ready = c > t_end ? 1'b1 : 1'($urandom_range(0, 1));
      v = pair_valid; rdy = pair_ready; pr = pair_ref; pm = pair_mic;
      tick;
      if (v && rdy) begin
        if (k < 1000) chk($sformatf("t5_pair%0d", k), {pr, pm}, {rv[k], mv[k]});
        else begin
          checks++; errors++;
          $display("FAIL t5_extra: got unexpected pair 0x%0h/0x%0h", pr, pm);
        end
        k++;
      end else if (v) chk("t5_hold", {pair_valid, pair_ref, pair_mic}, {1'b1, pr, pm});
    end
    ref_wren = 0; mic_wren = 0;
    chk("t5_count", k, 1000);
    chk("t5_ovf", ovf_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
